// File: rtl/video_timing_gen.sv
// Raster timing, pixel coordinates, scaled source-window coordinates and line prefetch requests, all registered and aligned.
// Optional FRAME_LOCK_EN: stretches vertical blanking until frameSync arrives, bounded by LOCK_MAX_EXTRA lines.
module video_timing_gen #(
  parameter int H_ACTIVE       = 1280,
  parameter int H_TOTAL        = 1650,
  parameter int H_SYNC_START   = 1390,
  parameter int H_SYNC_LEN     = 40,
  parameter int V_ACTIVE       = 720,
  parameter int V_TOTAL        = 750,
  parameter int V_SYNC_START   = 725,
  parameter int V_SYNC_LEN     = 5,
  parameter int SYNC_POL       = 1,
  parameter int SCALE          = 4,
  parameter int SRC_W          = 240,
  parameter int SRC_H          = 160,
  parameter int WIN_X0         = 160,
  parameter int WIN_Y0         = 40,
  parameter int LOCK_MAX_EXTRA = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameSync,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        frameStart,
  output logic        inWindow,
  output logic [7:0]  srcX,
  output logic [7:0]  srcY,
  output logic [2:0]  scaleX,
  output logic [2:0]  scaleY,
  output logic        lineReq,
  output logic [7:0]  reqLine
);

  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] HT_M1    = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS0      = 11'(H_SYNC_START);
  localparam logic [10:0] HS1      = 11'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] VT_M1    = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS0      = 11'(V_SYNC_START);
  localparam logic [10:0] VS1      = 11'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [10:0] WX0      = 11'(WIN_X0);
  localparam logic [10:0] WX1      = 11'(WIN_X0 + SRC_W * SCALE);
  localparam logic [10:0] WY0      = 11'(WIN_Y0);
  localparam logic [10:0] WY1      = 11'(WIN_Y0 + SRC_H * SCALE);
  localparam logic [10:0] WY0_M1   = 11'(WIN_Y0 - 1);
  localparam logic [2:0]  SC_M1    = 3'(SCALE - 1);
  localparam logic [7:0]  SRC_H_M1 = 8'(SRC_H - 1);
  localparam logic        ACT      = (SYNC_POL != 0);

  logic        started;
  logic [10:0] nx, ny;
  logic        line_end, wrap;
  logic        de_n, row_n, col_n;
  logic        req_n;
  logic [7:0]  req_line_n;

`ifdef FRAME_LOCK_EN
  localparam logic [10:0] VMAX = 11'(V_TOTAL - 1 + LOCK_MAX_EXTRA);
  logic armed;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frameSync;
`endif

  // The first cycle out of reset must present (0,0), so advancing starts one cycle later.
  always_comb begin
    nx       = 11'd0;
    ny       = 11'd0;
    line_end = 1'b0;
    wrap     = 1'b0;
    if (started) begin
      line_end = (x == HT_M1);
`ifdef FRAME_LOCK_EN
      wrap = line_end && (y >= VT_M1) && (armed || (y == VMAX));
`else
      wrap = line_end && (y == VT_M1);
`endif
      nx = line_end ? 11'd0 : x + 11'd1;
      ny = wrap ? 11'd0 : (line_end ? y + 11'd1 : y);
    end
  end

  assign de_n  = (nx < HA) && (ny < VA);
  assign row_n = (ny >= WY0) && (ny < WY1);
  assign col_n = (nx >= WX0) && (nx < WX1);

  // Registered srcY/scaleY already describe the current line when x reaches H_ACTIVE.
  always_comb begin
    req_n      = 1'b0;
    req_line_n = 8'd0;
    if (nx == HA) begin
      if (ny == WY0_M1) begin
        req_n = 1'b1;
      end else if ((ny >= WY0) && (ny < WY1) && (scaleY == SC_M1) && (srcY != SRC_H_M1)) begin
        req_n      = 1'b1;
        req_line_n = srcY + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started    <= 1'b0;
      x          <= 11'd0;
      y          <= 11'd0;
      de         <= 1'b0;
      hsync      <= !ACT;
      vsync      <= !ACT;
      frameStart <= 1'b0;
      inWindow   <= 1'b0;
      srcX       <= 8'd0;
      scaleX     <= 3'd0;
      srcY       <= 8'd0;
      scaleY     <= 3'd0;
      lineReq    <= 1'b0;
      reqLine    <= 8'd0;
    end else begin
      started    <= 1'b1;
      x          <= nx;
      y          <= ny;
      de         <= de_n;
      hsync      <= ((nx >= HS0) && (nx < HS1)) ? ACT : !ACT;
      vsync      <= ((ny >= VS0) && (ny < VS1)) ? ACT : !ACT;
      frameStart <= (nx == 11'd0) && (ny == 11'd0);
      inWindow   <= de_n && row_n && col_n;
      lineReq    <= req_n;
      reqLine    <= req_line_n;

      if (row_n && col_n && (nx != WX0)) begin
        if (scaleX == SC_M1) begin
          scaleX <= 3'd0;
          srcX   <= srcX + 8'd1;
        end else begin
          scaleX <= scaleX + 3'd1;
        end
      end else begin
        scaleX <= 3'd0;
        srcX   <= 8'd0;
      end

      if (nx == 11'd0) begin
        if (row_n && (ny != WY0)) begin
          if (scaleY == SC_M1) begin
            scaleY <= 3'd0;
            srcY   <= srcY + 8'd1;
          end else begin
            scaleY <= scaleY + 3'd1;
          end
        end else begin
          scaleY <= 3'd0;
          srcY   <= 8'd0;
        end
      end
    end
  end

`ifdef FRAME_LOCK_EN
  // A frameSync coinciding with the wrap arms the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (frameSync) begin
      armed <= 1'b1;
    end else if (wrap) begin
      armed <= 1'b0;
    end
  end
`endif

endmodule
